// File: rtl/ntsc_pkg.sv
// Shared NTSC timing defaults, derived totals and porch FSM encoding,
// used by the timing generator and the downstream pattern/encoder stages.
package ntsc_pkg;

    localparam int H_ACTIVE_DEF = 600;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 56;
    localparam int H_BACK_DEF   = 88;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_ACTIVE_DEF = 240;
    localparam int V_FRONT_DEF  = 3;
    localparam int V_SYNC_DEF   = 3;
    localparam int V_BACK_DEF   = 16;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int X_W = 10;
    localparam int Y_W = 9;

    // Horizontal instance: H_ACT/H_FP/H_SY/H_BP; vertical: V_ACT/V_FP/V_SY/V_BP.
    typedef enum logic [1:0] {
        ST_ACT = 2'd0,
        ST_FP  = 2'd1,
        ST_SY  = 2'd2,
        ST_BP  = 2'd3
    } porch_state_t;

    function automatic porch_state_t porch_next(input porch_state_t s);
        case (s)
            ST_ACT:  return ST_FP;
            ST_FP:   return ST_SY;
            ST_SY:   return ST_BP;
            default: return ST_ACT;
        endcase
    endfunction

endpackage

// File: rtl/ntsc_timing_if.sv
// Timing bus: pixel enable into the generator, position and sync flags out.
interface ntsc_timing_if;
    import ntsc_pkg::*;

    logic           pixel_tick;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           active_video;
    logic           hsync;
    logic           vsync;
    logic           csync;
    logic           line_start;
    logic           frame_start;

    modport master (
        input  pixel_tick,
        output x, y, active_video, hsync, vsync, csync, line_start, frame_start
    );

    modport slave (
        output pixel_tick,
        input  x, y, active_video, hsync, vsync, csync, line_start, frame_start
    );

endinterface

// File: rtl/sync_counter.sv
// Wrapping position counter with a 4-state porch FSM that tracks the count.
//   state  | meaning
//   ST_ACT | count in active region
//   ST_FP  | count in front porch
//   ST_SY  | count in sync pulse window
//   ST_BP  | count in back porch, wraps to ST_ACT at TOTAL-1
module sync_counter
    import ntsc_pkg::*;
#(
    parameter int ACTIVE = 600,
    parameter int FRONT  = 16,
    parameter int SYNC   = 56,
    parameter int BACK   = 88,
    parameter int WIDTH  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o,
    output logic             pulse_o,
    output logic             active_d_o,
    output logic             pulse_d_o
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
    localparam logic [WIDTH-1:0] LAST_ACT = WIDTH'(ACTIVE - 1);
    localparam logic [WIDTH-1:0] LAST_FP  = WIDTH'(ACTIVE + FRONT - 1);
    localparam logic [WIDTH-1:0] LAST_SY  = WIDTH'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [WIDTH-1:0] LAST_TOT = WIDTH'(TOTAL - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    porch_state_t     state_q, state_d;
    logic             pulse_q;
    logic [WIDTH-1:0] last_cnt;
    logic             tc;

    assign tc = (cnt_q == LAST_TOT);

    always_comb begin
        last_cnt = LAST_TOT;
        case (state_q)
            ST_ACT:  last_cnt = LAST_ACT;
            ST_FP:   last_cnt = LAST_FP;
            ST_SY:   last_cnt = LAST_SY;
            default: last_cnt = LAST_TOT;
        endcase

        cnt_d   = cnt_q;
        state_d = state_q;
        if (en_i) begin
            cnt_d = tc ? '0 : cnt_q + WIDTH'(1);
            if (cnt_q == last_cnt) begin
                state_d = porch_next(state_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= ST_ACT;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pulse_q <= (state_d == ST_SY);
        end
    end

    assign cnt_o      = cnt_q;
    assign wrap_o     = en_i & tc;
    assign pulse_o    = pulse_q;
    assign active_d_o = (state_d == ST_ACT);
    assign pulse_d_o  = (state_d == ST_SY);

endmodule

// File: rtl/ntsc_timing.sv
// NTSC raster timing: horizontal counter stepped by pixel_tick, vertical
// counter stepped by the horizontal wrap; all flags registered alongside x/y.
module ntsc_timing
    import ntsc_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF
) (
    input  logic          clk,
    input  logic          rst,
    ntsc_timing_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > (1 << X_W)) begin : g_h_too_big
        $error("ntsc_timing: H_TOTAL does not fit x");
    end
    if (V_TOTAL > (1 << Y_W)) begin : g_v_too_big
        $error("ntsc_timing: V_TOTAL does not fit y");
    end

    logic h_wrap, h_pulse, h_act_d, h_pulse_d;
    logic v_wrap, v_pulse, v_act_d, v_pulse_d;

    sync_counter #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .WIDTH(X_W)
    ) u_h (
        .clk        (clk),
        .rst        (rst),
        .en_i       (bus.pixel_tick),
        .cnt_o      (bus.x),
        .wrap_o     (h_wrap),
        .pulse_o    (h_pulse),
        .active_d_o (h_act_d),
        .pulse_d_o  (h_pulse_d)
    );

    sync_counter #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .WIDTH(Y_W)
    ) u_v (
        .clk        (clk),
        .rst        (rst),
        .en_i       (h_wrap),
        .cnt_o      (bus.y),
        .wrap_o     (v_wrap),
        .pulse_o    (v_pulse),
        .active_d_o (v_act_d),
        .pulse_d_o  (v_pulse_d)
    );

    logic active_q, csync_q, line_start_q, frame_start_q;

    // Flags are built from the counters' next state so they land with x/y.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q      <= 1'b1;
            csync_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            active_q      <= h_act_d & v_act_d;
            csync_q       <= h_pulse_d ^ v_pulse_d;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
        end
    end

    assign bus.active_video = active_q;
    assign bus.hsync        = h_pulse;
    assign bus.vsync        = v_pulse;
    assign bus.csync        = csync_q;
    assign bus.line_start   = line_start_q;
    assign bus.frame_start  = frame_start_q;

endmodule

// File: tb/tb_ntsc_timing.sv
// Scoreboard bench: stimulus pushes model predictions, monitor compares each clk.
module tb_ntsc_timing;

    typedef struct {
        int x; int y;
        bit av; bit hs; bit vs; bit cs; bit ls; bit fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1, rst1 = 1'b1;
    always #5 clk = ~clk;

    ntsc_timing_if bus0 ();
    ntsc_timing_if bus1 ();

    ntsc_timing dut0 (.clk(clk), .rst(rst0), .bus(bus0.master));

    ntsc_timing #(
        .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut1 (.clk(clk), .rst(rst1), .bus(bus1.master));

    int errors = 0;
    int checks = 0;
    exp_t q0[$];
    exp_t q1[$];
    int mx0 = 0, my0 = 0, mx1 = 0, my1 = 0;

    int hs0 = 0, ls0 = 0, fs0 = 0, av0 = 0;
    int hs1 = 0, vs1 = 0, ls1 = 0, fs1 = 0, av1 = 0, maxx1 = 0, maxy1 = 0;

    function automatic exp_t model(input int px, input int py, input bit tick, input bit r,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb);
        exp_t e;
        int ht, vt;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        e.ls = 0; e.fs = 0;
        if (r) begin
            e.x = 0; e.y = 0;
        end else if (tick) begin
            if (px == ht - 1) begin
                e.x = 0;
                e.y = (py == vt - 1) ? 0 : py + 1;
                e.ls = 1;
                e.fs = (e.y == 0);
            end else begin
                e.x = px + 1; e.y = py;
            end
        end else begin
            e.x = px; e.y = py;
        end
        e.av = (e.x < ha) && (e.y < va);
        e.hs = (e.x >= ha + hf) && (e.x < ha + hf + hsw);
        e.vs = (e.y >= va + vf) && (e.y < va + vf + vsw);
        e.cs = e.hs ^ e.vs;
        return e;
    endfunction

    task automatic cmp(input string nm, input exp_t e, input logic [9:0] gx, input logic [8:0] gy,
                       input logic av, input logic hs, input logic vs, input logic cs,
                       input logic ls, input logic fs);
        checks++;
        if (gx !== 10'(e.x) || gy !== 9'(e.y) || av !== e.av || hs !== e.hs ||
            vs !== e.vs || cs !== e.cs || ls !== e.ls || fs !== e.fs) begin
            errors++;
            $display("FAIL %s t=%0t: got x=%0d y=%0d av=%b hs=%b vs=%b cs=%b ls=%b fs=%b, expected x=%0d y=%0d av=%b hs=%b vs=%b cs=%b ls=%b fs=%b",
                     nm, $time, gx, gy, av, hs, vs, cs, ls, fs,
                     e.x, e.y, e.av, e.hs, e.vs, e.cs, e.ls, e.fs);
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Monitor: outputs are stable 1 ns after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            cmp("dut0_cycle", e, bus0.x, bus0.y, bus0.active_video, bus0.hsync, bus0.vsync,
                bus0.csync, bus0.line_start, bus0.frame_start);
            hs0 += int'(bus0.hsync); ls0 += int'(bus0.line_start);
            fs0 += int'(bus0.frame_start); av0 += int'(bus0.active_video);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("dut1_cycle", e, bus1.x, bus1.y, bus1.active_video, bus1.hsync, bus1.vsync,
                bus1.csync, bus1.line_start, bus1.frame_start);
            hs1 += int'(bus1.hsync); vs1 += int'(bus1.vsync); ls1 += int'(bus1.line_start);
            fs1 += int'(bus1.frame_start); av1 += int'(bus1.active_video);
            if (int'(bus1.x) > maxx1) maxx1 = int'(bus1.x);
            if (int'(bus1.y) > maxy1) maxy1 = int'(bus1.y);
        end
    end

    task automatic step(input bit t0, input bit r0, input bit t1, input bit r1);
        exp_t e0, e1;
        bus0.pixel_tick = t0; rst0 = r0;
        bus1.pixel_tick = t1; rst1 = r1;
        e0 = model(mx0, my0, t0, r0, 600, 16, 56, 88, 240, 3, 3, 16);
        e1 = model(mx1, my1, t1, r1, 8, 1, 2, 1, 4, 1, 1, 1);
        q0.push_back(e0); q1.push_back(e1);
        mx0 = e0.x; my0 = e0.y; mx1 = e1.x; my1 = e1.y;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_hs, s_ls, s_fs, s_av, s_vs;
        logic [15:0] pat;
        bus0.pixel_tick = 1'b0;
        bus1.pixel_tick = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) step(1, 1, 1, 1);
        chk("reset_x", int'(bus0.x), 0);
        chk("reset_av", int'(bus0.active_video), 1);

        // Three full default lines with continuous ticks.
        s_hs = hs0; s_ls = ls0; s_fs = fs0; s_av = av0;
        for (int i = 0; i < 3 * 760; i++) step(1, 0, 0, 0);
        chk("dut0_hsync_clks", hs0 - s_hs, 3 * 56);
        chk("dut0_line_starts", ls0 - s_ls, 3);
        chk("dut0_frame_starts", fs0 - s_fs, 0);
        chk("dut0_active_clks", av0 - s_av, 3 * 600);
        chk("dut0_y_after_3_lines", int'(bus0.y), 3);

        // Hold behaviour mid-line at x=100.
        for (int i = 0; i < 100; i++) step(1, 0, 0, 0);
        chk("hold_start_x", int'(bus0.x), 100);
        step(1, 0, 0, 0); chk("hold_x_a", int'(bus0.x), 101);
        step(0, 0, 0, 0); chk("hold_x_b", int'(bus0.x), 101);
        step(0, 0, 0, 0); chk("hold_x_c", int'(bus0.x), 101);
        step(1, 0, 0, 0); chk("hold_x_d", int'(bus0.x), 102);

        // Mid-frame reset at x=300 with pixel_tick still high.
        for (int i = 0; i < 198; i++) step(1, 0, 0, 0);
        chk("pre_rst_x", int'(bus0.x), 300);
        s_fs = fs0;
        step(1, 1, 0, 0);
        chk("mid_rst_x", int'(bus0.x), 0);
        chk("mid_rst_y", int'(bus0.y), 0);
        step(1, 0, 0, 0);
        chk("post_rst_x", int'(bus0.x), 1);
        chk("mid_rst_frame_starts", fs0 - s_fs, 0);

        // Small raster: two complete frames from the reset position.
        s_hs = hs1; s_ls = ls1; s_fs = fs1; s_av = av1; s_vs = vs1;
        for (int i = 0; i < 2 * 84; i++) step(0, 0, 1, 0);
        chk("dut1_active_clks", av1 - s_av, 64);
        chk("dut1_frame_starts", fs1 - s_fs, 2);
        chk("dut1_line_starts", ls1 - s_ls, 14);
        chk("dut1_hsync_clks", hs1 - s_hs, 28);
        chk("dut1_vsync_clks", vs1 - s_vs, 24);
        chk("dut1_max_x", maxx1, 11);
        chk("dut1_max_y", maxy1, 6);

        // Irregular tick pattern across wraps, then a short reset.
        pat = 16'b1011_0010_1110_0101;
        for (int r = 0; r < 10; r++)
            for (int b = 0; b < 16; b++) step(0, 0, pat[b], 0);
        step(0, 0, 1, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
        chk("dut1_post_rst_x", int'(bus1.x), 8);

        step(0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ntsc_timing.md
NTSC_TIMING -- requirements
Module: ntsc_timing

Interface
REQ-001 Parameter H_ACTIVE, default 600: active pixels per line.
REQ-002 Parameter H_FRONT, default 16: horizontal front porch, in ticks.
REQ-003 Parameter H_SYNC, default 56: horizontal sync width, in ticks.
REQ-004 Parameter H_BACK, default 88: horizontal back porch; line total H_TOTAL = 760.
REQ-005 Parameters V_ACTIVE 240, V_FRONT 3, V_SYNC 3, V_BACK 16, in lines; frame total V_TOTAL = 262.
REQ-006 Port clk, input, 1: single system clock; all logic SHALL be on its rising edge.
REQ-007 Port rst, input, 1: reset, synchronous, active-high.
REQ-008 Port pixel_tick, input, 1: pixel clock enable; counters SHALL advance only when it is 1.
REQ-009 Port x, output, 10: current horizontal position, 0..H_TOTAL-1.
REQ-010 Port y, output, 9: current vertical line, 0..V_TOTAL-1.
REQ-011 Port active_video, output, 1: high iff x < H_ACTIVE and y < V_ACTIVE.
REQ-012 Ports hsync and vsync, outputs, 1 each: active-high sync pulses.
REQ-013 Port csync, output, 1: composite sync.
REQ-014 Ports line_start and frame_start, outputs, 1 each: single-clk strobes.

Function
REQ-015 The horizontal FSM SHALL have states H_ACT, H_FP, H_SY and H_BP, in that order.
REQ-016 Horizontal transitions SHALL occur on the tick at which x reaches the last count of the current state.
REQ-017 The vertical FSM SHALL have states V_ACT, V_FP, V_SY and V_BP, and SHALL advance only on ticks where x wraps from H_TOTAL-1 to 0.
REQ-018 x SHALL increment by 1 per tick and wrap from H_TOTAL-1 to 0; y SHALL increment on each x wrap and wrap from V_TOTAL-1 to 0.
REQ-019 All outputs SHALL be registered and SHALL always describe the current (x,y): zero cycles of skew between x/y and the flags.
REQ-020 hsync SHALL be 1 for x in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], i.e. 616..671.
REQ-021 vsync SHALL be 1 for y in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], i.e. 243..245.
REQ-022 csync SHALL equal hsync XOR vsync, giving inverted pulses during vsync lines.
REQ-023 line_start SHALL be 1 for exactly one clk, in the cycle after the tick that sets x to 0.
REQ-024 frame_start SHALL be 1 for exactly one clk, in the cycle after the tick that sets x=0 and y=0.
REQ-025 When pixel_tick=0, x, y and all level outputs SHALL hold; line_start and frame_start SHALL be 0.
REQ-026 Continuous pixel_tick=1 SHALL be legal and SHALL yield one pixel per clk.
REQ-027 x and y SHALL never exceed H_TOTAL-1 and V_TOTAL-1 respectively.
REQ-028 Parameter sums SHALL fit the port widths: H_TOTAL <= 1024 and V_TOTAL <= 512.

Reset
REQ-029 While rst=1, the block SHALL drive x=0, y=0, active_video=1, hsync=0, vsync=0, csync=0, line_start=0, frame_start=0.
REQ-030 While rst=1, both FSMs SHALL be in H_ACT and V_ACT.
REQ-031 rst SHALL take priority over pixel_tick.
REQ-032 rst asserted mid-frame SHALL return all state to the reset values on the next edge, with no strobe emitted.
REQ-033 The first tick after reset release SHALL move x to 1; the reset position counts as pixel 0 of frame 0, with no frame_start for it.

Structure
REQ-034 Timing defaults, derived totals and FSM state encodings SHALL reside in a shared package, ntsc_pkg, for reuse by the downstream pattern and encoder stages.
REQ-035 A sub-module sync_counter SHALL implement one parameterised wrapping counter with enable, a 4-state porch FSM, terminal-count and pulse-window outputs.
REQ-036 ntsc_timing SHALL instantiate sync_counter twice: horizontal, and vertical enabled by the horizontal wrap.

Verification
REQ-037 Reset, then pixel_tick=1 continuously -> x runs 0..759 then 0; line_start high for 1 clk each time x becomes 0; y increments at each wrap.
REQ-038 Same stimulus -> hsync high for exactly 56 clks (x 616..671) every line; vsync high for exactly 3 lines (y 243..245); csync = hsync^vsync on every clk.
REQ-039 One full frame -> active_video high for exactly 144000 clks; low for all x >= 600 or y >= 240; frame_start once per 199120 ticks.
REQ-040 pixel_tick toggling 1,0,0,1 mid-line at x=100 -> x reads 101, 101, 101, 102; no strobes on the held cycles.
REQ-041 rst pulsed at x=300, y=100 -> next clk x=0, y=0, active_video=1, all syncs 0, no frame_start; the count then resumes from 1.
REQ-042 Parameters overridden to H_ACTIVE=8, H_FRONT=1, H_SYNC=2, H_BACK=1, V 4/1/1/1 -> H_TOTAL=12 and V_TOTAL=7 wrap correctly; hsync at x 9..10.
